// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative radix-2 multiply/divide unit with HI/LO registers
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] hi_wdata,
    input  logic [WIDTH-1:0] lo_wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_raw;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               b_zero;

    logic               is_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign is_signed = ~op[0];
    assign a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;

    // Multiply: acc_lo holds the multiplier and shifts out as product bits shift in.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

    // Divide: acc_lo holds the dividend and collects quotient bits from the right.
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd});
    assign div_diff  = div_shift[WIDTH-1:0] - opnd;

    assign prod_mag  = {acc_hi, acc_lo};
    assign prod_fix  = neg_q ? -prod_mag : prod_mag;
    assign quot_fix  = neg_q ? -acc_lo : acc_lo;
    assign rem_fix   = neg_r ? -acc_hi : acc_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            a_raw  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mthi) hi <= hi_wdata;
                    if (mtlo) lo <= lo_wdata;
                    if (start && !flush) begin
                        state  <= S_CALC;
                        busy   <= 1'b1;
                        cnt    <= CNT_W'(WIDTH);
                        is_div <= op[1];
                        neg_q  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r  <= is_signed & a[WIDTH-1];
                        b_zero <= (b == '0);
                        a_raw  <= a;
                        acc_hi <= '0;
                        acc_lo <= op[1] ? a_mag : b_mag;
                        opnd   <= op[1] ? b_mag : a_mag;
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (is_div) begin
                            acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                        end else begin
                            {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                        end
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    if (!flush) begin
                        done <= 1'b1;
                        if (!is_div) begin
                            {hi, lo} <= prod_fix;
                        end else if (b_zero) begin
                            hi <= a_raw;
                            lo <= '1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed vector bench for mul_div_unit
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        mthi;
    logic        mtlo;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .mthi     (mthi),
        .mtlo     (mtlo),
        .hi_wdata (hi_wdata),
        .lo_wdata (lo_wdata),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Called at a negedge; launches immediately and returns at the negedge where done=1.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
        int cyc;
        int bcnt;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        bcnt  = 0;
        while (!done && cyc < 60) begin
            if (busy) bcnt++;
            @(negedge clk);
            cyc++;
        end
        chk({name, " latency"}, 32'(cyc), 32'd34);
        chk({name, " busy_cycles"}, 32'(bcnt), 32'd33);
        chk({name, " busy_at_done"}, 32'(busy), 32'd0);
        chk({name, " hi"}, hi, ehi);
        chk({name, " lo"}, lo, elo);
    endtask

    task automatic expect_no_done(input string name, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4]  = '{2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        vecs[5]  = '{2'b01, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C};
        vecs[6]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[7]  = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[8]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[10] = '{2'b00, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
        vecs[11] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};

        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; flush = 1'b0;
        mthi = 1'b0; mtlo = 1'b0; hi_wdata = '0; lo_wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
            @(negedge clk);
            chk($sformatf("vec%0d done_pulse", i), 32'(done), 32'd0);
        end

        // Preload, then flush mid-MULTU; stray start and mthi while busy must be ignored.
        mthi = 1'b1; mtlo = 1'b1; hi_wdata = 32'h1234; lo_wdata = 32'h5678;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        chk("preload hi", hi, 32'h1234);
        chk("preload lo", lo, 32'h5678);
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3;
        mthi = 1'b1; hi_wdata = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy before flush", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("busy after flush", 32'(busy), 32'd0);
        expect_no_done("no done after flush", 40);
        chk("flush hi kept", hi, 32'h1234);
        chk("flush lo kept", lo, 32'h5678);

        // Flush in IDLE blocks a same-cycle start.
        start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd5; b = 32'd5;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("idle flush blocks start", 32'(busy), 32'd0);
        expect_no_done("idle flush no done", 40);

        // mthi together with start: write lands first, result overwrites later.
        mthi = 1'b1; hi_wdata = 32'hAAAA;
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
        @(negedge clk);
        mthi = 1'b0; start = 1'b0;
        chk("mthi with start lands", hi, 32'hAAAA);
        chk("mthi with start busy", 32'(busy), 32'd1);
        begin : wait_done
            int n;
            n = 0;
            while (!done && n < 60) begin
                @(negedge clk);
                n++;
            end
            chk("overwrite done seen", 32'(done), 32'd1);
            chk("overwrite hi", hi, 32'd0);
            chk("overwrite lo", lo, 32'hC);
        end

        // Back-to-back: new start in the done cycle.
        @(negedge clk);
        run_op("b2b first", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("b2b second", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);

        // Asynchronous reset mid-DIV.
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd50; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset busy", 32'(busy), 32'd0);
        chk("async reset hi", hi, 32'd0);
        chk("async reset lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_no_done("no done after reset", 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
